// File: rtl/vga_scan_reader_if.sv
// Read port between the VGA scan reader (master) and the 1-bit frame store (slave).
interface vga_scan_reader_if;
    logic       mem_ready;
    logic       color;
    logic [9:0] readX;
    logic [9:0] readY;

    modport master (input mem_ready, input color, output readX, output readY);
    modport slave  (output mem_ready, output color, input readX, input readY);
endinterface

// File: rtl/vga_scan_reader.sv
// 640x480@60 VGA scan master for the 1-bit frame store; sync/blank delay-matched to MEM_LATENCY.
// Optional macro VGA_SCAN_BORDER_EN forces FG_RGB on the outermost ring of active pixels.
module vga_scan_reader #(
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          MEM_LATENCY = 2,
    parameter logic [11:0] FG_RGB      = 12'hFFF,
    parameter logic [11:0] BG_RGB      = 12'h000
) (
    input  logic                clk,
    input  logic                reset_n,
    vga_scan_reader_if.master   mem,
    output logic                hsync,
    output logic                vsync,
    output logic [3:0]          vga_r,
    output logic [3:0]          vga_g,
    output logic [3:0]          vga_b,
    output logic                frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] VA     = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1023) begin : g_h_range
        $error("vga_scan_reader: H_TOTAL does not fit a 10-bit counter");
    end
    if (V_TOTAL > 1023) begin : g_v_range
        $error("vga_scan_reader: V_TOTAL does not fit a 10-bit counter");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_lat_range
        $error("vga_scan_reader: MEM_LATENCY must be 1..4");
    end

    typedef enum logic {WAIT_MEM, SCAN} state_t;

    typedef struct packed {
        logic active;
`ifdef VGA_SCAN_BORDER_EN
        logic border;
`endif
        logic hs;
        logic vs;
        logic fs;
    } tm_t;

    state_t      state, state_nxt;
    logic [9:0]  hcount, vcount;
    logic        scan;
    tm_t         tm0;
    tm_t         tm_pipe [1:MEM_LATENCY];
    tm_t         tm_l;
    logic        pix_on;
    logic [11:0] rgb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_MEM;
        else          state <= state_nxt;
    end

    // Once scanning, mem_ready is deliberately ignored until the next reset.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_MEM: if (mem.mem_ready) state_nxt = SCAN;
            SCAN:     state_nxt = SCAN;
            default:  state_nxt = WAIT_MEM;
        endcase
    end

    assign scan = (state == SCAN);

    // Counters stay at 0 through the WAIT_MEM->SCAN edge so the first frame is whole.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (!scan) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    always_comb begin
        tm0        = '0;
        tm0.active = scan && (hcount < HA) && (vcount < VA);
`ifdef VGA_SCAN_BORDER_EN
        tm0.border = tm0.active && (hcount == 10'd0 || hcount == HA - 10'd1 ||
                                    vcount == 10'd0 || vcount == VA - 10'd1);
`endif
        tm0.hs     = !(scan && hcount >= HS_BEG && hcount <= HS_END);
        tm0.vs     = !(scan && vcount >= VS_BEG && vcount <= VS_END);
        tm0.fs     = scan && (hcount == 10'd0) && (vcount == 10'd0);
    end

    assign mem.readX = tm0.active ? hcount : '0;
    assign mem.readY = tm0.active ? vcount : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i <= MEM_LATENCY; i++) begin
                tm_pipe[i]    <= '0;
                tm_pipe[i].hs <= 1'b1;
                tm_pipe[i].vs <= 1'b1;
            end
        end else begin
            tm_pipe[1] <= tm0;
            for (int i = 2; i <= MEM_LATENCY; i++) tm_pipe[i] <= tm_pipe[i-1];
        end
    end

    assign tm_l = tm_pipe[MEM_LATENCY];

`ifdef VGA_SCAN_BORDER_EN
    assign pix_on = mem.color || tm_l.border;
`else
    assign pix_on = mem.color;
`endif

    // color arrives in the same cycle as the last pipeline stage; blanking is always 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else begin
            hsync       <= tm_l.hs;
            vsync       <= tm_l.vs;
            frame_start <= tm_l.fs;
            rgb         <= !tm_l.active ? 12'h000 : (pix_on ? FG_RGB : BG_RGB);
        end
    end

    assign vga_r = rgb[11:8];
    assign vga_g = rgb[7:4];
    assign vga_b = rgb[3:0];
endmodule
